// File: rtl/mv_pkg.sv
// Shared definitions for the sequential matrix-vector multiplier: FSM states
// and the accumulator width rule.
package mv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Full-precision products plus enough headroom for DIM of them and a sign bit.
    function automatic int acc_w(input int width, input int dim);
        return 2 * width + $clog2(dim) + 1;
    endfunction

endpackage

// File: rtl/fx_mac.sv
// Combinational multiply-accumulate with floor-scaled, saturated row writeback.
// The caller owns the accumulator register.
module fx_mac #(
    parameter int WIDTH      = 32,
    parameter int FRAC_WIDTH = 30,
    parameter int ACC_W      = 66
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic signed [ACC_W-1:0] acc_in,
    output logic signed [ACC_W-1:0] acc_out,
    output logic signed [WIDTH-1:0] res,
    output logic                    ovf
);

    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] prod;
    logic        [WIDTH:0]     wb;

    // Arithmetic shift gives round-toward-minus-infinity.
    function automatic logic signed [ACC_W-1:0] scale(input logic signed [ACC_W-1:0] v);
        return v >>> FRAC_WIDTH;
    endfunction

    // Returns {clamped, value}.
    function automatic logic [WIDTH:0] sat(input logic signed [ACC_W-1:0] v);
        if (v > SAT_HI)
            return {1'b1, SAT_HI[WIDTH-1:0]};
        else if (v < SAT_LO)
            return {1'b1, SAT_LO[WIDTH-1:0]};
        else
            return {1'b0, v[WIDTH-1:0]};
    endfunction

    assign prod    = a * b;
    assign acc_out = acc_in + {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
    assign wb      = sat(scale(acc_out));
    assign ovf     = wb[WIDTH];
    assign res     = wb[WIDTH-1:0];

endmodule

// File: rtl/mv_seq.sv
// Sequential fixed-point matrix-vector multiplier: one MAC per cycle over the
// registered operands, result held under a valid/ready handshake.
module mv_seq
    import mv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int FRAC_WIDTH = 30,
    parameter int DIM        = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DIM*DIM*WIDTH-1:0]   mat,
    input  logic [DIM*WIDTH-1:0]       vec,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DIM*WIDTH-1:0]       res,
    output logic [DIM-1:0]             ovf
);

    localparam int ACC_W = acc_w(WIDTH, DIM);
    localparam int IW    = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int MW    = (DIM > 1) ? $clog2(DIM * DIM) : 1;

    state_t                   state;
    logic [IW-1:0]            row, col;
    logic [MW-1:0]            midx;
    logic [DIM*DIM*WIDTH-1:0] mat_r;
    logic [DIM*WIDTH-1:0]     vec_r;
    logic signed [ACC_W-1:0]  acc, acc_nxt;
    logic signed [WIDTH-1:0]  m_e   [DIM*DIM];
    logic signed [WIDTH-1:0]  v_e   [DIM];
    logic signed [WIDTH-1:0]  res_e [DIM];
    logic [DIM-1:0]           ovf_r;
    logic signed [WIDTH-1:0]  row_res;
    logic                     row_ovf;
    logic                     last_col, last_row;

    for (genvar g = 0; g < DIM * DIM; g++) begin : g_mat
        assign m_e[g] = mat_r[g*WIDTH +: WIDTH];
    end

    for (genvar g = 0; g < DIM; g++) begin : g_vec
        assign v_e[g]               = vec_r[g*WIDTH +: WIDTH];
        assign res[g*WIDTH +: WIDTH] = res_e[g];
    end

    assign midx     = MW'(int'(row) * DIM + int'(col));
    assign last_col = (col == IW'(DIM - 1));
    assign last_row = (row == IW'(DIM - 1));

    fx_mac #(
        .WIDTH      (WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH),
        .ACC_W      (ACC_W)
    ) u_mac (
        .a       (m_e[midx]),
        .b       (v_e[col]),
        .acc_in  (acc),
        .acc_out (acc_nxt),
        .res     (row_res),
        .ovf     (row_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
            acc   <= '0;
            mat_r <= '0;
            vec_r <= '0;
            ovf_r <= '0;
            for (int i = 0; i < DIM; i++) res_e[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mat_r <= mat;
                        vec_r <= vec;
                        row   <= '0;
                        col   <= '0;
                        acc   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Row writeback uses the sum including this cycle's product.
                    if (last_col) begin
                        res_e[row] <= row_res;
                        ovf_r[row] <= row_ovf;
                        acc        <= '0;
                        col        <= '0;
                        if (last_row)
                            state <= DONE;
                        else
                            row <= row + 1'b1;
                    end else begin
                        acc <= acc_nxt;
                        col <= col + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_mv_seq.sv
// Randomised and directed bench for mv_seq (WIDTH=32, FRAC_WIDTH=30, DIM=2)
// against an arithmetic reference model.
module tb_mv_seq;

    localparam int W = 32;
    localparam int F = 30;
    localparam int D = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [D*D*W-1:0] mat;
    logic [D*W-1:0]   vec;
    logic             out_valid;
    logic             out_ready;
    logic [D*W-1:0]   res;
    logic [D-1:0]     ovf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mv_seq #(.WIDTH(W), .FRAC_WIDTH(F), .DIM(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mat       (mat),
        .vec       (vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // res[r] = sat(floor(sum_c m(r,c)*v[c] / 2^F)) in wide plain arithmetic.
    function automatic void model(input logic [D*D*W-1:0] m, input logic [D*W-1:0] v,
                                  output logic [D*W-1:0] r, output logic [D-1:0] o);
        logic signed [127:0] s, a, b, q;
        for (int i = 0; i < D; i++) begin
            s = '0;
            for (int c = 0; c < D; c++) begin
                a = $signed(m[(i*D+c)*W +: W]);
                b = $signed(v[c*W +: W]);
                s = s + a * b;
            end
            q = s >>> F;
            if (q > 128'sd2147483647) begin
                r[i*W +: W] = 32'h7FFFFFFF;
                o[i] = 1'b1;
            end else if (q < -128'sd2147483648) begin
                r[i*W +: W] = 32'h80000000;
                o[i] = 1'b1;
            end else begin
                r[i*W +: W] = q[W-1:0];
                o[i] = 1'b0;
            end
        end
    endfunction

    function automatic logic [D*D*W-1:0] mk(input logic [31:0] a00, a01, a10, a11);
        return {a11, a10, a01, a00};
    endfunction

    function automatic logic [31:0] rnd();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 2))
            0:       return x;
            1:       return {{3{x[28]}}, x[28:0]};
            default: return {{10{x[21]}}, x[21:0]};
        endcase
    endfunction

    task automatic txn(input string tag, input logic [D*D*W-1:0] m, input logic [D*W-1:0] v,
                       input logic [D*W-1:0] er, input logic [D-1:0] eo, input int hold);
        int lat;
        @(negedge clk);
        check({tag, " idle in_ready"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        mat       = m;
        vec       = v;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        check({tag, " busy in_ready"}, 64'(in_ready), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        mat      = {$urandom, $urandom, $urandom, $urandom};
        vec      = {$urandom, $urandom};
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(D * D));
        check({tag, " res"}, 64'(res), 64'(er));
        check({tag, " ovf"}, 64'(ovf), 64'(eo));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = $urandom_range(0, 1) == 1;
            mat      = {$urandom, $urandom, $urandom, $urandom};
            vec      = {$urandom, $urandom};
            @(posedge clk);
            #1;
            check({tag, " hold res"}, 64'(res), 64'(er));
            check({tag, " hold valid/ready"}, {62'd0, out_valid, in_ready}, 64'b10);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " released"}, {62'd0, out_valid, in_ready}, 64'b01);
    endtask

    task automatic rtxn(input string tag, input int hold);
        logic [D*D*W-1:0] m;
        logic [D*W-1:0]   v, er;
        logic [D-1:0]     eo;
        m = mk(rnd(), rnd(), rnd(), rnd());
        v = {rnd(), rnd()};
        model(m, v, er, eo);
        txn(tag, m, v, er, eo, hold);
    endtask

    initial begin
        logic seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mat       = '0;
        vec       = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset res", 64'(res), 64'd0);
        check("reset ovf", 64'(ovf), 64'd0);
        check("reset valid/ready", {62'd0, out_valid, in_ready}, 64'b01);
        @(negedge clk);
        rst = 1'b0;

        txn("identity", mk(32'h40000000, 0, 0, 32'h40000000), {32'hF0000000, 32'h20000000},
            {32'hF0000000, 32'h20000000}, 2'b00, 0);
        txn("halves", mk(32'h20000000, 32'h20000000, 32'h20000000, 32'hE0000000),
            {32'h20000000, 32'h40000000}, {32'h10000000, 32'h30000000}, 2'b00, 0);
        txn("sat_pos", mk(32'h60000000, 32'h60000000, 32'h60000000, 32'h60000000),
            {32'h60000000, 32'h60000000}, {32'h7FFFFFFF, 32'h7FFFFFFF}, 2'b11, 0);
        txn("sat_neg", mk(32'h60000000, 32'h60000000, 32'h60000000, 32'h60000000),
            {32'hA0000000, 32'hA0000000}, {32'h80000000, 32'h80000000}, 2'b11, 0);
        txn("floor_neg", mk(32'hFFFFFFFF, 0, 0, 0), {32'h0, 32'h1}, {32'h0, 32'hFFFFFFFF}, 2'b00, 0);
        txn("floor_pos", mk(32'h1, 0, 0, 0), {32'h0, 32'h1}, {32'h0, 32'h0}, 2'b00, 0);
        txn("backpressure", mk(32'h20000000, 32'h20000000, 32'h20000000, 32'hE0000000),
            {32'h20000000, 32'h40000000}, {32'h10000000, 32'h30000000}, 2'b00, 5);

        // Abort on the second RUN cycle; nothing may be presented afterwards.
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        mat       = mk(32'h60000000, 32'h60000000, 32'h60000000, 32'h60000000);
        vec       = {32'h60000000, 32'h60000000};
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort res", 64'(res), 64'd0);
        check("abort ovf", 64'(ovf), 64'd0);
        check("abort valid/ready", {62'd0, out_valid, in_ready}, 64'b01);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            seen |= out_valid;
        end
        check("abort no out_valid", 64'(seen), 64'd0);
        txn("after_abort", mk(32'h40000000, 0, 0, 32'h40000000), {32'hF0000000, 32'h20000000},
            {32'hF0000000, 32'h20000000}, 2'b00, 0);

        for (int k = 0; k < 40; k++) rtxn("random", $urandom_range(0, 2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
